// File: rtl/cop_pkg.sv
// Shared coprocessor definitions: issue FSM encoding, opcodes, instruction fields.
package cop_pkg;

   // Issue FSM encoding
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } cu_state_t;

   // Opcodes carried in instr[2:0]; 3'b111 is reserved and rejected
   typedef enum logic [2:0] {
      OP_CMD0    = 3'd0,
      OP_CMD1    = 3'd1,
      OP_CMD2    = 3'd2,
      OP_CMD3    = 3'd3,
      OP_CMD4    = 3'd4,
      OP_CMD5    = 3'd5,
      OP_CMD6    = 3'd6,
      OP_ILLEGAL = 3'd7
   } op_t;

   // Instruction field positions
   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OP_LSB   = 0;
   localparam int unsigned OP_W     = 3;
   localparam int unsigned SIZE_LSB = 3;
   localparam int unsigned SIZE_W   = 2;
   localparam int unsigned CMD_W    = OP_W + SIZE_W;

   // Queued command payload; bit layout mirrors instr[4:0]
   typedef struct packed {
      logic [SIZE_W-1:0] mat_size;
      logic [OP_W-1:0]   op;
   } cmd_t;

   // Extract the decoded fields from the low instruction bits
   function automatic cmd_t decode_instr(input logic [CMD_W-1:0] instr);
      cmd_t c;
      c.op       = instr[OP_LSB +: OP_W];
      c.mat_size = instr[SIZE_LSB +: SIZE_W];
      return c;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with level count; DEPTH must be a power of two.
module cmd_fifo
   import cop_pkg::*;
#(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cmd_issue_unit.sv
// Command issue stage: HPS req/ack intake, command queue, single-pulse issue to
// the control unit, completion tracking and sticky status.
// Build option: CMD_FIFO_EN selects a DEPTH-entry FIFO; otherwise a single
// holding register is used and new commands wait for the previous completion.
module cmd_issue_unit
   import cop_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hps_req,
   input  logic [INSTR_W-1:0]       hps_instr,
   output logic                     hps_ack,
   input  logic                     clr_status,
   input  logic                     cu_ready,
   input  logic                     cu_overflow,
   output logic                     start,
   output logic [OP_W-1:0]          op_code,
   output logic [SIZE_W-1:0]        mat_size,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     ovf_sticky,
   output logic                     err_illegal,
   output logic [CNT_W-1:0]         done_cnt
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   cu_state_t        state;
   cmd_t             in_cmd_c;
   cmd_t             q_head;
   logic             q_empty;
   logic [LVL_W-1:0] q_level;
   logic [LVL_W-1:0] lvl_nxt_c;
   logic             in_illegal_c;
   logic             can_accept_c;
   logic             accept_c;
   logic             push_c;
   logic             pop_c;
   logic             done_c;
   logic             busy_nxt_c;
   logic             unused_instr_hi;

   assign in_cmd_c        = decode_instr(hps_instr[CMD_W-1:0]);
   assign unused_instr_hi = ^hps_instr[INSTR_W-1:CMD_W];
   assign in_illegal_c    = (in_cmd_c.op == OP_ILLEGAL);
   assign accept_c        = hps_req & ~hps_ack & can_accept_c;
   assign push_c          = accept_c & ~in_illegal_c;
   assign pop_c           = (state == IDLE) & ~q_empty & cu_ready;
   assign done_c          = (state == WAIT_DONE) & cu_ready;
   assign lvl_nxt_c       = q_level + LVL_W'(push_c) - LVL_W'(pop_c);
   assign busy_nxt_c      = pop_c | (state == ISSUE) | (state == WAIT_BUSY) |
                            ((state == WAIT_DONE) & ~cu_ready) | (lvl_nxt_c != '0);
   assign fifo_level      = q_level;

`ifdef CMD_FIFO_EN
   logic q_full;

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .pop   (pop_c),
      .din   (in_cmd_c),
      .dout  (q_head),
      .full  (q_full),
      .empty (q_empty),
      .level (q_level)
   );

   assign can_accept_c = ~q_full;
`else
   logic hold_vld;
   cmd_t hold_cmd;

   // Single-entry holding register; refilled only once the unit is fully idle
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_vld <= 1'b0;
         hold_cmd <= '0;
      end else begin
         if (pop_c) hold_vld <= 1'b0;
         if (push_c) begin
            hold_vld <= 1'b1;
            hold_cmd <= in_cmd_c;
         end
      end
   end

   assign q_head       = hold_cmd;
   assign q_empty      = ~hold_vld;
   assign q_level      = LVL_W'(hold_vld);
   assign can_accept_c = ~hold_vld & (state == IDLE);
`endif

   // Issue FSM with registered start/opcode/size and completion status
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         start      <= 1'b0;
         op_code    <= '0;
         mat_size   <= '0;
         ovf_sticky <= 1'b0;
         done_cnt   <= '0;
      end else begin
         start <= 1'b0;
         case (state)
            IDLE: begin
               if (pop_c) begin
                  state    <= ISSUE;
                  start    <= 1'b1;
                  op_code  <= q_head.op;
                  mat_size <= q_head.mat_size;
               end
            end
            ISSUE:     state <= WAIT_BUSY;
            WAIT_BUSY: if (!cu_ready) state <= WAIT_DONE;
            WAIT_DONE: if (cu_ready) state <= IDLE;
            default:   state <= IDLE;
         endcase
         // Clear beats a coincident completion, but the completion still counts
         if (clr_status) begin
            ovf_sticky <= 1'b0;
            done_cnt   <= CNT_W'(done_c);
         end else if (done_c) begin
            ovf_sticky <= ovf_sticky | cu_overflow;
            done_cnt   <= done_cnt + CNT_W'(1);
         end
      end
   end

   // Four-phase acknowledge, illegal-word flag and busy indication
   always_ff @(posedge clk) begin
      if (rst) begin
         hps_ack     <= 1'b0;
         err_illegal <= 1'b0;
         busy        <= 1'b0;
      end else begin
         if (accept_c)                hps_ack <= 1'b1;
         else if (hps_ack & ~hps_req) hps_ack <= 1'b0;
         if (accept_c & in_illegal_c) err_illegal <= 1'b1;
         else if (clr_status)         err_illegal <= 1'b0;
         busy <= busy_nxt_c;
      end
   end

endmodule

// File: tb/tb_cmd_issue_unit.sv
// Directed bench for cmd_issue_unit with a simple control-unit responder.
module tb_cmd_issue_unit;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
`ifdef CMD_FIFO_EN
   localparam int CAP = DEPTH;
`else
   localparam int CAP = 1;
`endif
   localparam int QN = (CAP >= 2) ? 2 : 0;

   logic             clk = 1'b0;
   logic             rst;
   logic             hps_req;
   logic [31:0]      hps_instr;
   logic             hps_ack;
   logic             clr_status;
   logic             cu_ready;
   logic             cu_overflow;
   logic             start;
   logic [2:0]       op_code;
   logic [1:0]       mat_size;
   logic             busy;
   logic [LVL_W-1:0] fifo_level;
   logic             ovf_sticky;
   logic             err_illegal;
   logic [CNT_W-1:0] done_cnt;

   logic             cu_hold;
   logic             mdl_ready;
   logic             mdl_pend;
   int               mdl_cnt;
   logic [2:0]       issued_op[$];
   logic [1:0]       issued_sz[$];

   int n_checks = 0;
   int n_pass   = 0;

   cmd_issue_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .hps_req     (hps_req),
      .hps_instr   (hps_instr),
      .hps_ack     (hps_ack),
      .clr_status  (clr_status),
      .cu_ready    (cu_ready),
      .cu_overflow (cu_overflow),
      .start       (start),
      .op_code     (op_code),
      .mat_size    (mat_size),
      .busy        (busy),
      .fifo_level  (fifo_level),
      .ovf_sticky  (ovf_sticky),
      .err_illegal (err_illegal),
      .done_cnt    (done_cnt)
   );

   always #5 clk = ~clk;

   assign cu_ready = mdl_ready & ~cu_hold;

   // Control unit: drops ready the cycle after start, returns it 10 cycles later
   always @(negedge clk) begin
      if (rst) begin
         mdl_ready = 1'b1;
         mdl_pend  = 1'b0;
         mdl_cnt   = 0;
      end else begin
         if (mdl_cnt > 0) begin
            mdl_cnt = mdl_cnt - 1;
            if (mdl_cnt == 0) mdl_ready = 1'b1;
         end
         if (start) begin
            issued_op.push_back(op_code);
            issued_sz.push_back(mat_size);
            mdl_pend = 1'b1;
         end else if (mdl_pend) begin
            mdl_pend  = 1'b0;
            mdl_ready = 1'b0;
            mdl_cnt   = 10;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] cmd_word(input int i);
      logic [31:0] w;
      w = {27'd0, 2'(i), 3'(i)};
      return w;
   endfunction

   function automatic logic [31:0] q_op(input int i);
      return (i < issued_op.size()) ? 32'(issued_op[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] q_sz(input int i);
      return (i < issued_sz.size()) ? 32'(issued_sz[i]) : 32'hFFFF_FFFF;
   endfunction

   // Full four-phase transfer of one word, bounded on both ack edges
   task automatic push_word(input logic [31:0] w);
      int n;
      hps_instr = w;
      hps_req   = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!hps_ack && n < 200);
      check("push_ack_rise", 32'(hps_ack), 32'd1);
      hps_req = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (hps_ack && n < 20);
      check("push_ack_fall", 32'(hps_ack), 32'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || !cu_ready || mdl_pend) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(n < 500), 32'd1);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      hps_req     = 1'b1;
      hps_instr   = 32'h0000_0002;
      clr_status  = 1'b0;
      cu_overflow = 1'b0;
      cu_hold     = 1'b0;

      // Reset held with req asserted: nothing moves
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_ack", 32'(hps_ack), 32'd0);
         check("rst_start", 32'(start), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_level", 32'(fifo_level), 32'd0);
      end
      check("rst_op", 32'(op_code), 32'd0);
      check("rst_size", 32'(mat_size), 32'd0);
      check("rst_ovf", 32'(ovf_sticky), 32'd0);
      check("rst_err", 32'(err_illegal), 32'd0);
      check("rst_done", 32'(done_cnt), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_first_ack", 32'(hps_ack), 32'd1);
      hps_req = 1'b0;
      wait_idle();
      check("rst_cmd_done", 32'(done_cnt), 32'd1);
      check("rst_cmd_op", q_op(0), 32'd2);
      clr_pulse();
      check("clr_done", 32'(done_cnt), 32'd0);

      // Single command 0x9: op 1, size 1, exact issue timing
      issued_op.delete();
      issued_sz.delete();
      hps_instr = 32'h0000_0009;
      hps_req   = 1'b1;
      @(negedge clk);
      check("single_ack", 32'(hps_ack), 32'd1);
      check("single_lvl_push", 32'(fifo_level), 32'd1);
      hps_req = 1'b0;
      @(negedge clk);
      check("single_start", 32'(start), 32'd1);
      check("single_op", 32'(op_code), 32'd1);
      check("single_size", 32'(mat_size), 32'd1);
      check("single_lvl_pop", 32'(fifo_level), 32'd0);
      check("single_busy", 32'(busy), 32'd1);
      wait_idle();
      check("single_nstart", 32'(issued_op.size()), 32'd1);
      check("single_done", 32'(done_cnt), 32'd1);
      check("single_ovf", 32'(ovf_sticky), 32'd0);
      check("single_op_hold", 32'(op_code), 32'd1);

      // Illegal opcode: acked, flagged, dropped
      clr_pulse();
      issued_op.delete();
      issued_sz.delete();
      hps_instr = 32'h0000_0007;
      hps_req   = 1'b1;
      @(negedge clk);
      check("ill_ack", 32'(hps_ack), 32'd1);
      check("ill_err", 32'(err_illegal), 32'd1);
      check("ill_level", 32'(fifo_level), 32'd0);
      hps_req = 1'b0;
      repeat (4) @(negedge clk);
      check("ill_nstart", 32'(issued_op.size()), 32'd0);
      check("ill_busy", 32'(busy), 32'd0);
      check("ill_ack_fall", 32'(hps_ack), 32'd0);
      clr_pulse();
      check("ill_clr", 32'(err_illegal), 32'd0);

      // Queue full with CU held busy; ordering preserved after release
      issued_op.delete();
      issued_sz.delete();
      cu_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == CAP) begin
            hps_instr = cmd_word(i);
            hps_req   = 1'b1;
            repeat (6) @(negedge clk);
            check("full_stall", 32'(hps_ack), 32'd0);
            check("full_level", 32'(fifo_level), 32'(CAP));
            check("full_nstart", 32'(issued_op.size()), 32'd0);
            cu_hold = 1'b0;
         end
         push_word(cmd_word(i));
      end
      wait_idle();
      check("full_nstart_all", 32'(issued_op.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check("full_order_op", q_op(i), 32'(i));
         check("full_order_sz", q_sz(i), 32'(i % 4));
      end
      check("full_done", 32'(done_cnt), 32'd5);

      // Overflow sticky, then clear coinciding with the next completion
      clr_pulse();
      cu_overflow = 1'b1;
      push_word(32'h0000_0003);
      wait_idle();
      check("ovf_set", 32'(ovf_sticky), 32'd1);
      check("ovf_done", 32'(done_cnt), 32'd1);
      push_word(32'h0000_0004);
      cu_hold = 1'b1;
      repeat (15) @(negedge clk);
      check("race_waiting", 32'(busy), 32'd1);
      cu_hold    = 1'b0;
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      check("race_ovf", 32'(ovf_sticky), 32'd0);
      check("race_done", 32'(done_cnt), 32'd1);
      check("race_busy", 32'(busy), 32'd0);
      cu_overflow = 1'b0;

      // Reset in WAIT_DONE with queued work
      issued_op.delete();
      issued_sz.delete();
      push_word(32'h0000_001A);
      cu_hold = 1'b1;
      for (int i = 0; i < QN; i++) push_word(cmd_word(i + 1));
      repeat (3) @(negedge clk);
      check("mid_level", 32'(fifo_level), 32'(QN));
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_op", 32'(op_code), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_level", 32'(fifo_level), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_op", 32'(op_code), 32'd0);
      check("mid_rst_size", 32'(mat_size), 32'd0);
      check("mid_rst_done", 32'(done_cnt), 32'd0);
      rst     = 1'b0;
      cu_hold = 1'b0;
      repeat (30) @(negedge clk);
      check("mid_no_start", 32'(issued_op.size()), 32'd1);
      check("mid_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
